i2c_xlate_table_ctrl: RTL and testbench

Programmable address-remap table and lookup sequencer for the I2C address translator. When the translator captures a 7-bit target address, it issues a lookup. This block scans its table one entry per cycle and returns a translated (physical) address plus a hit flag. A host-side config port writes and reads table entries and is arbitrated against lookups, so the table is never modified mid-scan.

---
 rtl/i2c_xlate_table_ctrl_if.sv | 31 +++
 rtl/i2c_xlate_table_ctrl.sv | 154 +++++++++++++++
 tb/tb_i2c_xlate_table_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_xlate_table_ctrl_if.sv
// Lookup and config handshake bundle for the I2C address-translation table.
// The master side is the address capture / host logic, the slave side is the table controller.
interface i2c_xlate_table_ctrl_if #(
   parameter int IDX_W = 2
);
   logic             lkp_valid;
   logic             lkp_ready;
   logic [6:0]       lkp_addr;
   logic             lkp_ack;
   logic             lkp_hit;
   logic [6:0]       lkp_phys;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_write;
   logic [IDX_W-1:0] cfg_index;
   logic             cfg_en;
   logic [6:0]       cfg_virt;
   logic [6:0]       cfg_phys;
   logic             cfg_rvalid;
   logic [14:0]      cfg_rdata;

   modport master (
      output lkp_valid, lkp_addr, cfg_valid, cfg_write, cfg_index, cfg_en, cfg_virt, cfg_phys,
      input  lkp_ready, lkp_ack, lkp_hit, lkp_phys, cfg_ready, cfg_rvalid, cfg_rdata
   );

   modport slave (
      input  lkp_valid, lkp_addr, cfg_valid, cfg_write, cfg_index, cfg_en, cfg_virt, cfg_phys,
      output lkp_ready, lkp_ack, lkp_hit, lkp_phys, cfg_ready, cfg_rvalid, cfg_rdata
   );
endinterface

// File: rtl/i2c_xlate_table_ctrl.sv
// Address-remap table with a one-entry-per-cycle lookup scanner and an
// arbitrated host config port; config is only served while no scan is running.
//
// state | meaning
// IDLE  | accepting lookups, or config accesses when no lookup is requested
// SCAN  | comparing entry[idx] against the latched virtual address
// RESP  | lkp_ack pulse; hit/phys results held afterwards
module i2c_xlate_table_ctrl #(
   parameter int         ENTRIES   = 4,
   parameter logic [6:0] RST_VIRT0 = 7'h49,
   parameter logic [6:0] RST_PHYS0 = 7'h48
) (
   input  logic                  clk,
   input  logic                  reset,
   i2c_xlate_table_ctrl_if.slave bus,
   output logic [7:0]            hit_count,
   output logic                  busy
);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [6:0]       addr_q, addr_d;
   logic             ack_q, ack_d;
   logic             hit_q, hit_d;
   logic [6:0]       lphys_q, lphys_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             rvalid_q, rvalid_d;
   logic [14:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             en_q    [ENTRIES];
   logic             en_d    [ENTRIES];
   logic [6:0]       virt_q  [ENTRIES];
   logic [6:0]       virt_d  [ENTRIES];
   logic [6:0]       tphys_q [ENTRIES];
   logic [6:0]       tphys_d [ENTRIES];

   logic cfg_in_range;
   logic lkp_acc;
   logic cfg_acc;

   assign cfg_in_range = (int'(bus.cfg_index) < ENTRIES);
   assign lkp_acc      = (state_q == IDLE) && bus.lkp_valid;
   assign cfg_acc      = (state_q == IDLE) && bus.cfg_valid && !bus.lkp_valid;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      ack_d    = 1'b0;
      hit_d    = hit_q;
      lphys_d  = lphys_q;
      cnt_d    = cnt_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      en_d     = en_q;
      virt_d   = virt_q;
      tphys_d  = tphys_q;

      case (state_q)
         IDLE: begin
            if (lkp_acc) begin
               addr_d  = bus.lkp_addr;
               idx_d   = '0;
               state_d = SCAN;
            end else if (cfg_acc) begin
               if (bus.cfg_write) begin
                  if (cfg_in_range) begin
                     en_d[bus.cfg_index]    = bus.cfg_en;
                     virt_d[bus.cfg_index]  = bus.cfg_virt;
                     tphys_d[bus.cfg_index] = bus.cfg_phys;
                  end
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = cfg_in_range ? {en_q[bus.cfg_index], virt_q[bus.cfg_index],
                                             tphys_q[bus.cfg_index]} : 15'd0;
               end
            end
         end
         SCAN: begin
            // Scanning upward makes the lowest matching index win on duplicates.
            if (en_q[idx_q] && (virt_q[idx_q] == addr_q)) begin
               state_d = RESP;
               ack_d   = 1'b1;
               hit_d   = 1'b1;
               lphys_d = tphys_q[idx_q];
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end else if (idx_q == IDX_W'(ENTRIES - 1)) begin
               state_d = RESP;
               ack_d   = 1'b1;
               hit_d   = 1'b0;
               lphys_d = addr_q;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         ack_q    <= 1'b0;
         hit_q    <= 1'b0;
         lphys_q  <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            en_q[i]    <= (i == 0);
            virt_q[i]  <= (i == 0) ? RST_VIRT0 : 7'd0;
            tphys_q[i] <= (i == 0) ? RST_PHYS0 : 7'd0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         ack_q    <= ack_d;
         hit_q    <= hit_d;
         lphys_q  <= lphys_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         virt_q   <= virt_d;
         tphys_q  <= tphys_d;
      end
   end

   // cfg_ready must drop the same cycle a lookup request appears, so it cannot be fully registered.
   assign bus.lkp_ready  = ready_q;
   assign bus.cfg_ready  = ready_q & ~bus.lkp_valid;
   assign bus.lkp_ack    = ack_q;
   assign bus.lkp_hit    = hit_q;
   assign bus.lkp_phys   = lphys_q;
   assign bus.cfg_rvalid = rvalid_q;
   assign bus.cfg_rdata  = rdata_q;
   assign hit_count      = cnt_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_i2c_xlate_table_ctrl.sv
// Directed self-checking bench for i2c_xlate_table_ctrl (ENTRIES=4 main instance,
// ENTRIES=5 second instance so an out-of-range index is expressible).
module tb_i2c_xlate_table_ctrl;
   logic       clk;
   logic       reset;
   logic [7:0] hit_count;
   logic       busy;
   logic [7:0] hit_count2;
   logic       busy2;
   int         passed;
   int         total;

   i2c_xlate_table_ctrl_if #(.IDX_W(2)) bus ();
   i2c_xlate_table_ctrl_if #(.IDX_W(3)) bus2 ();

   i2c_xlate_table_ctrl #(.ENTRIES(4), .RST_VIRT0(7'h49), .RST_PHYS0(7'h48)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .hit_count (hit_count),
      .busy      (busy)
   );

   i2c_xlate_table_ctrl #(.ENTRIES(5), .RST_VIRT0(7'h49), .RST_PHYS0(7'h48)) u_dut5 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus2),
      .hit_count (hit_count2),
      .busy      (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_lookup(input logic [6:0] a, output int lat, output logic hit,
                            output logic [6:0] phys);
      int t;
      int c;
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = a;
      t = 0;
      while (!bus.lkp_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.lkp_valid = 1'b0;
      c = 1;
      while (!bus.lkp_ack && c < 40) begin
         @(negedge clk);
         c++;
      end
      lat  = bus.lkp_ack ? c : -1;
      hit  = bus.lkp_hit;
      phys = bus.lkp_phys;
   endtask

   task automatic cfg_wr(input logic [1:0] idx, input logic en, input logic [6:0] v,
                         input logic [6:0] p);
      int t;
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      bus.cfg_write = 1'b1;
      bus.cfg_index = idx;
      bus.cfg_en    = en;
      bus.cfg_virt  = v;
      bus.cfg_phys  = p;
      t = 0;
      while (!bus.cfg_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.cfg_write = 1'b0;
   endtask

   task automatic cfg_rd(input logic [1:0] idx, output logic rv, output logic [14:0] rd);
      int t;
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      bus.cfg_write = 1'b0;
      bus.cfg_index = idx;
      t = 0;
      while (!bus.cfg_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      @(negedge clk);
      rv = bus.cfg_rvalid;
      rd = bus.cfg_rdata;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      total++; if (bus.lkp_ready !== 1'b1) $display("FAIL reset_lkp_ready: got %b want 1", bus.lkp_ready); else passed++;
      total++; if (bus.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (bus.lkp_ack !== 1'b0 || bus.lkp_hit !== 1'b0 || bus.lkp_phys !== 7'h00)
         $display("FAIL reset_lkp_outs: got ack=%b hit=%b phys=%h want 0/0/00", bus.lkp_ack, bus.lkp_hit, bus.lkp_phys);
      else passed++;
      total++; if (bus.cfg_rvalid !== 1'b0 || bus.cfg_rdata !== 15'h0000)
         $display("FAIL reset_cfg_outs: got rvalid=%b rdata=%h want 0/0000", bus.cfg_rvalid, bus.cfg_rdata);
      else passed++;
      total++; if (hit_count !== 8'h00) $display("FAIL reset_hit_count: got %h want 00", hit_count); else passed++;
   endtask

   task automatic test_default_hit;
      int lat; logic hit; logic [6:0] phys;
      do_lookup(7'h49, lat, hit, phys);
      total++; if (lat !== 2) $display("FAIL hit_latency: got %0d want 2", lat); else passed++;
      total++; if (hit !== 1'b1 || phys !== 7'h48) $display("FAIL hit_result: got hit=%b phys=%h want 1/48", hit, phys); else passed++;
      total++; if (hit_count !== 8'd1) $display("FAIL hit_count_1: got %0d want 1", hit_count); else passed++;
      @(negedge clk);
      total++; if (bus.lkp_ack !== 1'b0 || bus.lkp_hit !== 1'b1 || bus.lkp_phys !== 7'h48)
         $display("FAIL ack_pulse_hold: got ack=%b hit=%b phys=%h want 0/1/48", bus.lkp_ack, bus.lkp_hit, bus.lkp_phys);
      else passed++;
   endtask

   task automatic test_miss;
      int lat; logic hit; logic [6:0] phys;
      do_lookup(7'h50, lat, hit, phys);
      total++; if (lat !== 5) $display("FAIL miss_latency: got %0d want 5", lat); else passed++;
      total++; if (hit !== 1'b0 || phys !== 7'h50) $display("FAIL miss_result: got hit=%b phys=%h want 0/50", hit, phys); else passed++;
      total++; if (hit_count !== 8'd1) $display("FAIL miss_hit_count: got %0d want 1", hit_count); else passed++;
   endtask

   task automatic test_duplicate;
      int lat; logic hit; logic [6:0] phys; logic rv; logic [14:0] rd;
      cfg_wr(2'd2, 1'b1, 7'h21, 7'h20);
      cfg_wr(2'd3, 1'b1, 7'h21, 7'h30);
      cfg_rd(2'd3, rv, rd);
      total++; if (rv !== 1'b1 || rd !== 15'h50B0) $display("FAIL read_idx3: got rv=%b rdata=%h want 1/50b0", rv, rd); else passed++;
      do_lookup(7'h21, lat, hit, phys);
      total++; if (lat !== 4) $display("FAIL dup_latency: got %0d want 4", lat); else passed++;
      total++; if (hit !== 1'b1 || phys !== 7'h20) $display("FAIL dup_lowest_wins: got hit=%b phys=%h want 1/20", hit, phys); else passed++;
      total++; if (hit_count !== 8'd2) $display("FAIL dup_hit_count: got %0d want 2", hit_count); else passed++;
   endtask

   task automatic test_priority;
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = 7'h49;
      bus.cfg_valid = 1'b1;
      bus.cfg_write = 1'b0;
      bus.cfg_index = 2'd0;
      #1;
      total++; if (bus.cfg_ready !== 1'b0 || bus.lkp_ready !== 1'b1)
         $display("FAIL prio_ready: got cfg_ready=%b lkp_ready=%b want 0/1", bus.cfg_ready, bus.lkp_ready);
      else passed++;
      @(posedge clk);
      @(negedge clk);  // c=1
      bus.lkp_valid = 1'b0;
      total++; if (busy !== 1'b1 || bus.cfg_ready !== 1'b0)
         $display("FAIL prio_scan: got busy=%b cfg_ready=%b want 1/0", busy, bus.cfg_ready);
      else passed++;
      @(negedge clk);  // c=2
      total++; if (bus.lkp_ack !== 1'b1 || bus.lkp_hit !== 1'b1 || bus.cfg_rvalid !== 1'b0)
         $display("FAIL prio_lkp_first: got ack=%b hit=%b rvalid=%b want 1/1/0", bus.lkp_ack, bus.lkp_hit, bus.cfg_rvalid);
      else passed++;
      @(negedge clk);  // c=3
      total++; if (bus.cfg_ready !== 1'b1 || bus.cfg_rvalid !== 1'b0)
         $display("FAIL prio_cfg_ready: got cfg_ready=%b rvalid=%b want 1/0", bus.cfg_ready, bus.cfg_rvalid);
      else passed++;
      @(negedge clk);  // c=4
      bus.cfg_valid = 1'b0;
      total++; if (bus.cfg_rvalid !== 1'b1 || bus.cfg_rdata !== 15'h64C8)
         $display("FAIL prio_read: got rvalid=%b rdata=%h want 1/64c8", bus.cfg_rvalid, bus.cfg_rdata);
      else passed++;
      @(negedge clk);  // c=5
      total++; if (bus.cfg_rvalid !== 1'b0 || bus.cfg_rdata !== 15'h64C8)
         $display("FAIL prio_rdata_hold: got rvalid=%b rdata=%h want 0/64c8", bus.cfg_rvalid, bus.cfg_rdata);
      else passed++;
      total++; if (hit_count !== 8'd3) $display("FAIL prio_hit_count: got %0d want 3", hit_count); else passed++;
   endtask

   task automatic test_disable;
      int lat; logic hit; logic [6:0] phys;
      cfg_wr(2'd0, 1'b0, 7'h49, 7'h48);
      do_lookup(7'h49, lat, hit, phys);
      total++; if (lat !== 5 || hit !== 1'b0 || phys !== 7'h49)
         $display("FAIL disabled_entry: got lat=%0d hit=%b phys=%h want 5/0/49", lat, hit, phys);
      else passed++;
      total++; if (hit_count !== 8'd3) $display("FAIL disabled_hit_count: got %0d want 3", hit_count); else passed++;
   endtask

   task automatic test_out_of_range;
      int c;
      @(negedge clk);
      bus2.cfg_valid = 1'b1;
      bus2.cfg_write = 1'b0;
      bus2.cfg_index = 3'd0;
      @(negedge clk);
      total++; if (bus2.cfg_rvalid !== 1'b1 || bus2.cfg_rdata !== 15'h64C8)
         $display("FAIL oor_read_idx0: got rvalid=%b rdata=%h want 1/64c8", bus2.cfg_rvalid, bus2.cfg_rdata);
      else passed++;
      bus2.cfg_index = 3'd5;
      @(negedge clk);
      bus2.cfg_valid = 1'b0;
      total++; if (bus2.cfg_rvalid !== 1'b1 || bus2.cfg_rdata !== 15'h0000)
         $display("FAIL oor_read_idx5: got rvalid=%b rdata=%h want 1/0000", bus2.cfg_rvalid, bus2.cfg_rdata);
      else passed++;
      bus2.cfg_valid = 1'b1;
      bus2.cfg_write = 1'b1;
      bus2.cfg_index = 3'd5;
      bus2.cfg_en    = 1'b1;
      bus2.cfg_virt  = 7'h50;
      bus2.cfg_phys  = 7'h51;
      @(negedge clk);
      bus2.cfg_valid = 1'b0;
      bus2.cfg_write = 1'b0;
      total++; if (bus2.cfg_rvalid !== 1'b0) $display("FAIL oor_write_no_rvalid: got %b want 0", bus2.cfg_rvalid); else passed++;
      bus2.lkp_valid = 1'b1;
      bus2.lkp_addr  = 7'h50;
      @(posedge clk);
      @(negedge clk);
      bus2.lkp_valid = 1'b0;
      c = 1;
      while (!bus2.lkp_ack && c < 40) begin
         @(negedge clk);
         c++;
      end
      total++; if (!bus2.lkp_ack || c !== 6 || bus2.lkp_hit !== 1'b0 || bus2.lkp_phys !== 7'h50)
         $display("FAIL oor_write_ignored: got ack=%b lat=%0d hit=%b phys=%h want 1/6/0/50", bus2.lkp_ack, c, bus2.lkp_hit, bus2.lkp_phys);
      else passed++;
   endtask

   task automatic test_reset_mid_scan;
      int lat; logic hit; logic [6:0] phys; int acks;
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = 7'h77;
      @(posedge clk);
      @(negedge clk);
      bus.lkp_valid = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL mid_scan_busy: got %b want 1", busy); else passed++;
      reset = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || bus.lkp_ready !== 1'b1 || bus.lkp_ack !== 1'b0)
         $display("FAIL mid_scan_reset: got busy=%b lkp_ready=%b ack=%b want 0/1/0", busy, bus.lkp_ready, bus.lkp_ack);
      else passed++;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.lkp_ack) acks++;
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.lkp_ack) acks++;
      end
      total++; if (acks !== 0) $display("FAIL mid_scan_no_ack: got %0d acks want 0", acks); else passed++;
      total++; if (hit_count !== 8'd0) $display("FAIL mid_scan_count_clr: got %0d want 0", hit_count); else passed++;
      do_lookup(7'h49, lat, hit, phys);
      total++; if (lat !== 2 || hit !== 1'b1 || phys !== 7'h48)
         $display("FAIL table_restored_e0: got lat=%0d hit=%b phys=%h want 2/1/48", lat, hit, phys);
      else passed++;
      do_lookup(7'h21, lat, hit, phys);
      total++; if (lat !== 5 || hit !== 1'b0 || phys !== 7'h21)
         $display("FAIL table_restored_e2: got lat=%0d hit=%b phys=%h want 5/0/21", lat, hit, phys);
      else passed++;
   endtask

   task automatic test_back_to_back;
      int acks; int cyc; int last; int gap_bad; logic [7:0] cnt253;
      acks = 0; cyc = 0; last = -1; gap_bad = 0; cnt253 = 8'h00;
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = 7'h49;
      while (acks < 300 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (bus.lkp_ack) begin
            acks++;
            if (last >= 0 && (cyc - last) != 3) gap_bad++;
            last = cyc;
            if (acks == 253) cnt253 = hit_count;
         end
      end
      bus.lkp_valid = 1'b0;
      total++; if (acks !== 300) $display("FAIL b2b_ack_count: got %0d want 300", acks); else passed++;
      total++; if (gap_bad !== 0) $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); else passed++;
      total++; if (cnt253 !== 8'hFE) $display("FAIL count_before_sat: got %h want fe", cnt253); else passed++;
      @(negedge clk);
      @(negedge clk);
      total++; if (hit_count !== 8'hFF || busy !== 1'b0)
         $display("FAIL count_saturated: got count=%h busy=%b want ff/0", hit_count, busy);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b1;
      bus.lkp_valid  = 1'b0; bus.lkp_addr  = '0;
      bus.cfg_valid  = 1'b0; bus.cfg_write = 1'b0; bus.cfg_index = '0;
      bus.cfg_en     = 1'b0; bus.cfg_virt  = '0;   bus.cfg_phys  = '0;
      bus2.lkp_valid = 1'b0; bus2.lkp_addr  = '0;
      bus2.cfg_valid = 1'b0; bus2.cfg_write = 1'b0; bus2.cfg_index = '0;
      bus2.cfg_en    = 1'b0; bus2.cfg_virt  = '0;   bus2.cfg_phys  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_default_hit();
      test_miss();
      test_duplicate();
      test_priority();
      test_disable();
      test_out_of_range();
      test_reset_mid_scan();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
